// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle RV32I datapath and its main FSM.
// The datapath side (master) supplies opcode/flags/handshake; the FSM side
// (slave) returns the ALU operation, enables, mux selects and status pulses.
interface multicycle_control_if;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic [1:0] ALUOp;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic       mem_read;
  logic       mem_write;
  logic       i_or_d;
  logic       ir_write;
  logic       pc_en;
  logic       pc_src;
  logic       reg_write;
  logic       mem_to_reg;
  logic       instr_done;
  logic       illegal_op;
  logic       mem_fault;
  logic [3:0] state;

  modport master (
    output opcode, zero, mem_ready,
    input  ALUOp, alu_src_a, alu_src_b, mem_read, mem_write, i_or_d,
           ir_write, pc_en, pc_src, reg_write, mem_to_reg, instr_done,
           illegal_op, mem_fault, state
  );

  modport slave (
    input  opcode, zero, mem_ready,
    output ALUOp, alu_src_a, alu_src_b, mem_read, mem_write, i_or_d,
           ir_write, pc_en, pc_src, reg_write, mem_to_reg, instr_done,
           illegal_op, mem_fault, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle RV32I datapath (R-type, I-type ALU,
// load, store, beq). One state per cycle; outputs are decoded from the state
// register, with pc_en/ir_write/instr_done qualified by mem_ready or zero.
// Memory states wait on mem_ready and can optionally abort after
// MEM_TIMEOUT consecutive wait cycles.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 0
) (
  input  logic               clk,
  input  logic               reset,
  multicycle_control_if.slave bus
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXEC_R    = 4'd6,
    EXEC_I    = 4'd7,
    ALU_WB    = 4'd8,
    BRANCH    = 4'd9
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // The counter holds the number of earlier wait cycles in the current
  // memory state, so the abort fires on the MEM_TIMEOUT-th wait cycle.
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 2) + 1;
  localparam int TO_M1 = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_M1);

  state_t           state_q;
  state_t           state_n;
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_state;
  logic             timeout_hit;

  assign mem_state   = (state_q == FETCH) || (state_q == MEM_READ) ||
                       (state_q == MEM_WRITE);
  assign timeout_hit = (MEM_TIMEOUT > 0) && mem_state && !bus.mem_ready &&
                       (wait_cnt == TO_LAST);
  assign bus.state   = state_q;

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_n;
  end

  // Saturating count of consecutive mem_ready=0 cycles in a memory state.
  always_ff @(posedge clk) begin
    if (reset)
      wait_cnt <= '0;
    else if (!mem_state || bus.mem_ready || timeout_hit || (state_n != state_q))
      wait_cnt <= '0;
    else if (wait_cnt != {CNT_W{1'b1}})
      wait_cnt <= wait_cnt + CNT_W'(1);
  end

  // Next-state decode and per-state outputs; reset forces all outputs low.
  always_comb begin
    state_n        = state_q;
    bus.ALUOp      = 2'b00;
    bus.alu_src_a  = 2'b00;
    bus.alu_src_b  = 2'b00;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.i_or_d     = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_en      = 1'b0;
    bus.pc_src     = 1'b0;
    bus.reg_write  = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.instr_done = 1'b0;
    bus.illegal_op = 1'b0;
    bus.mem_fault  = 1'b0;

    case (state_q)
      FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        if (bus.mem_ready) begin
          bus.ir_write = 1'b1;
          bus.pc_en    = 1'b1;
          state_n      = DECODE;
        end else if (timeout_hit) begin
          bus.mem_fault = 1'b1;
          state_n       = FETCH;
        end
      end
      DECODE: begin
        // Branch target PC+imm is computed here into ALUOut.
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b10;
        case (bus.opcode)
          OP_R:               state_n = EXEC_R;
          OP_I:               state_n = EXEC_I;
          OP_LOAD, OP_STORE:  state_n = MEM_ADDR;
          OP_BRANCH:          state_n = BRANCH;
          default: begin
            bus.illegal_op = 1'b1;
            state_n        = FETCH;
          end
        endcase
      end
      MEM_ADDR: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b10;
        state_n = (bus.opcode == OP_STORE) ? MEM_WRITE : MEM_READ;
      end
      MEM_READ: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
        if (bus.mem_ready) begin
          state_n = MEM_WB;
        end else if (timeout_hit) begin
          bus.mem_fault = 1'b1;
          state_n       = FETCH;
        end
      end
      MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        bus.instr_done = 1'b1;
        state_n        = FETCH;
      end
      MEM_WRITE: begin
        bus.mem_write = 1'b1;
        bus.i_or_d    = 1'b1;
        if (bus.mem_ready) begin
          bus.instr_done = 1'b1;
          state_n        = FETCH;
        end else if (timeout_hit) begin
          bus.mem_fault = 1'b1;
          state_n       = FETCH;
        end
      end
      EXEC_R: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b00;
        bus.ALUOp     = 2'b10;
        state_n       = ALU_WB;
      end
      EXEC_I: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b10;
        bus.ALUOp     = 2'b10;
        state_n       = ALU_WB;
      end
      ALU_WB: begin
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
        state_n        = FETCH;
      end
      BRANCH: begin
        bus.alu_src_a  = 2'b01;
        bus.alu_src_b  = 2'b00;
        bus.ALUOp      = 2'b01;
        bus.pc_src     = 1'b1;
        bus.pc_en      = bus.zero;
        bus.instr_done = 1'b1;
        state_n        = FETCH;
      end
      default: state_n = FETCH;
    endcase

    if (reset) begin
      bus.ALUOp      = 2'b00;
      bus.alu_src_a  = 2'b00;
      bus.alu_src_b  = 2'b00;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.i_or_d     = 1'b0;
      bus.ir_write   = 1'b0;
      bus.pc_en      = 1'b0;
      bus.pc_src     = 1'b0;
      bus.reg_write  = 1'b0;
      bus.mem_to_reg = 1'b0;
      bus.instr_done = 1'b0;
      bus.illegal_op = 1'b0;
      bus.mem_fault  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (MEM_TIMEOUT=4). Each record is one
// clock cycle: inputs are driven after the falling edge, outputs are compared
// 1 ns later, and the next rising edge advances the FSM.
// Output vector layout (17 bits):
//   {ALUOp[1:0], alu_src_a[1:0], alu_src_b[1:0],
//    mem_read, mem_write, i_or_d, ir_write, pc_en, pc_src,
//    reg_write, mem_to_reg, instr_done, illegal_op, mem_fault}
module tb_multicycle_control;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_control_if bus ();

  multicycle_control #(.MEM_TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic        z;
    logic        rdy;
    logic [3:0]  st;
    logic [16:0] out;
    string       name;
  } vec_t;

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] I  = 7'b0010011;
  localparam logic [6:0] LW = 7'b0000011;
  localparam logic [6:0] SW = 7'b0100011;
  localparam logic [6:0] BQ = 7'b1100011;
  localparam logic [6:0] XX = 7'b1111111;

  // Hand-computed output vectors per state/condition.
  localparam logic [16:0] O_RST  = 17'b000000_00000000000;
  localparam logic [16:0] O_F1   = 17'b000001_10011000000;
  localparam logic [16:0] O_F0   = 17'b000001_10000000000;
  localparam logic [16:0] O_FTO  = 17'b000001_10000000001;
  localparam logic [16:0] O_DEC  = 17'b001010_00000000000;
  localparam logic [16:0] O_ILL  = 17'b001010_00000000010;
  localparam logic [16:0] O_MA   = 17'b000110_00000000000;
  localparam logic [16:0] O_MR   = 17'b000000_10100000000;
  localparam logic [16:0] O_MWB  = 17'b000000_00000011100;
  localparam logic [16:0] O_MW0  = 17'b000000_01100000000;
  localparam logic [16:0] O_MW1  = 17'b000000_01100000100;
  localparam logic [16:0] O_MWTO = 17'b000000_01100000001;
  localparam logic [16:0] O_ER   = 17'b100100_00000000000;
  localparam logic [16:0] O_EI   = 17'b100110_00000000000;
  localparam logic [16:0] O_AWB  = 17'b000000_00000010100;
  localparam logic [16:0] O_BZ1  = 17'b010100_00001100100;
  localparam logic [16:0] O_BZ0  = 17'b010100_00000100100;

  int n_vec  = 0;
  int n_fail = 0;

  function automatic logic [16:0] actual_out();
    return {bus.ALUOp, bus.alu_src_a, bus.alu_src_b,
            bus.mem_read, bus.mem_write, bus.i_or_d, bus.ir_write,
            bus.pc_en, bus.pc_src, bus.reg_write, bus.mem_to_reg,
            bus.instr_done, bus.illegal_op, bus.mem_fault};
  endfunction

  task automatic step(input logic rst, input logic [6:0] op, input logic z,
                      input logic rdy, input logic [3:0] st,
                      input logic [16:0] out, input string name);
    logic [16:0] act;
    @(negedge clk);
    reset         = rst;
    bus.opcode    = op;
    bus.zero      = z;
    bus.mem_ready = rdy;
    #1;
    act = actual_out();
    n_vec++;
    if (bus.state !== st || act !== out) begin
      n_fail++;
      $display("FAIL %s: state=%0d outputs=%b, required state=%0d outputs=%b",
               name, bus.state, act, st, out);
    end
    if (bus.mem_read === 1'b1 && bus.mem_write === 1'b1) begin
      n_fail++;
      $display("FAIL %s: mem_read and mem_write both 1, required at most one",
               name);
    end
  endtask

  vec_t tbl[$];

  function automatic vec_t v(input logic rst, input logic [6:0] op,
                             input logic z, input logic rdy,
                             input logic [3:0] st, input logic [16:0] out,
                             input string name);
    vec_t r;
    r.rst = rst; r.op = op; r.z = z; r.rdy = rdy;
    r.st = st; r.out = out; r.name = name;
    return r;
  endfunction

  initial begin
    // Reset, then R-type, I-type, load with waits, store, both beq outcomes,
    // an illegal opcode, and a reset in the middle of an R-type.
    tbl.push_back(v(1, R,  0, 1, 0, O_RST, "reset_hold1"));
    tbl.push_back(v(1, R,  0, 1, 0, O_RST, "reset_hold2"));
    tbl.push_back(v(0, R,  0, 1, 0, O_F1,  "add_fetch"));
    tbl.push_back(v(0, R,  0, 1, 1, O_DEC, "add_decode"));
    tbl.push_back(v(0, R,  0, 1, 6, O_ER,  "add_exec"));
    tbl.push_back(v(0, R,  0, 1, 8, O_AWB, "add_wb"));
    tbl.push_back(v(0, I,  0, 1, 0, O_F1,  "addi_fetch"));
    tbl.push_back(v(0, I,  0, 1, 1, O_DEC, "addi_decode"));
    tbl.push_back(v(0, I,  0, 1, 7, O_EI,  "addi_exec"));
    tbl.push_back(v(0, I,  0, 1, 8, O_AWB, "addi_wb"));
    tbl.push_back(v(0, LW, 0, 1, 0, O_F1,  "lw_fetch"));
    tbl.push_back(v(0, LW, 0, 1, 1, O_DEC, "lw_decode"));
    tbl.push_back(v(0, LW, 0, 1, 2, O_MA,  "lw_addr"));
    tbl.push_back(v(0, LW, 0, 0, 3, O_MR,  "lw_read_wait1"));
    tbl.push_back(v(0, LW, 0, 0, 3, O_MR,  "lw_read_wait2"));
    tbl.push_back(v(0, LW, 0, 1, 3, O_MR,  "lw_read_done"));
    tbl.push_back(v(0, LW, 0, 1, 4, O_MWB, "lw_wb"));
    tbl.push_back(v(0, SW, 0, 1, 0, O_F1,  "sw_fetch"));
    tbl.push_back(v(0, SW, 0, 1, 1, O_DEC, "sw_decode"));
    tbl.push_back(v(0, SW, 0, 1, 2, O_MA,  "sw_addr"));
    tbl.push_back(v(0, SW, 0, 1, 5, O_MW1, "sw_write"));
    tbl.push_back(v(0, BQ, 1, 1, 0, O_F1,  "beq1_fetch"));
    tbl.push_back(v(0, BQ, 1, 1, 1, O_DEC, "beq1_decode"));
    tbl.push_back(v(0, BQ, 1, 1, 9, O_BZ1, "beq_taken"));
    tbl.push_back(v(0, BQ, 0, 1, 0, O_F1,  "beq0_fetch"));
    tbl.push_back(v(0, BQ, 0, 1, 1, O_DEC, "beq0_decode"));
    tbl.push_back(v(0, BQ, 0, 1, 9, O_BZ0, "beq_not_taken"));
    tbl.push_back(v(0, XX, 0, 1, 0, O_F1,  "ill_fetch"));
    tbl.push_back(v(0, XX, 0, 1, 1, O_ILL, "ill_decode"));
    tbl.push_back(v(0, XX, 0, 0, 0, O_F0,  "ill_back_fetch_wait"));
    tbl.push_back(v(0, R,  0, 1, 0, O_F1,  "add2_fetch"));
    tbl.push_back(v(0, R,  0, 1, 1, O_DEC, "add2_decode"));
    tbl.push_back(v(1, R,  0, 1, 6, O_RST, "reset_mid_exec"));
    tbl.push_back(v(1, R,  0, 1, 0, O_RST, "reset_mid2"));
    tbl.push_back(v(1, R,  0, 1, 0, O_RST, "reset_mid3"));
    tbl.push_back(v(0, R,  0, 1, 0, O_F1,  "after_reset_fetch"));

    reset         = 1'b1;
    bus.opcode    = R;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    @(posedge clk);

    foreach (tbl[i])
      step(tbl[i].rst, tbl[i].op, tbl[i].z, tbl[i].rdy,
           tbl[i].st, tbl[i].out, tbl[i].name);

    // Store with mem_ready stuck low: abort on the 4th wait cycle.
    step(0, SW, 0, 1, 1, O_DEC,  "to_sw_decode");
    step(0, SW, 0, 1, 2, O_MA,   "to_sw_addr");
    step(0, SW, 0, 0, 5, O_MW0,  "to_sw_wait1");
    step(0, SW, 0, 0, 5, O_MW0,  "to_sw_wait2");
    step(0, SW, 0, 0, 5, O_MW0,  "to_sw_wait3");
    step(0, SW, 0, 0, 5, O_MWTO, "to_sw_fault");
    step(0, SW, 0, 1, 0, O_F1,   "to_sw_refetch");

    // Same store, but mem_ready arrives on the would-be abort cycle.
    step(0, SW, 0, 1, 1, O_DEC,  "race_sw_decode");
    step(0, SW, 0, 1, 2, O_MA,   "race_sw_addr");
    step(0, SW, 0, 0, 5, O_MW0,  "race_sw_wait1");
    step(0, SW, 0, 0, 5, O_MW0,  "race_sw_wait2");
    step(0, SW, 0, 0, 5, O_MW0,  "race_sw_wait3");
    step(0, SW, 0, 1, 5, O_MW1,  "race_sw_done");

    // Fetch timeout, followed by a fresh wait window in FETCH.
    step(0, R,  0, 0, 0, O_F0,   "fto_wait1");
    step(0, R,  0, 0, 0, O_F0,   "fto_wait2");
    step(0, R,  0, 0, 0, O_F0,   "fto_wait3");
    step(0, R,  0, 0, 0, O_FTO,  "fto_fault");
    step(0, R,  0, 0, 0, O_F0,   "fto_rewait1");
    step(0, R,  0, 0, 0, O_F0,   "fto_rewait2");
    step(0, R,  0, 1, 0, O_F1,   "fto_fetch_done");
    step(0, R,  0, 1, 1, O_DEC,  "fto_decode");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
